fpu_arbiter: RTL

FPU_ARBITER -- requirements
Module: fpu_arbiter

---
 rtl/fpu_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - two-requester round-robin front end for a shared FPU
// Optional WAIT watchdog enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_op_a,
  input  logic [63:0] req_op_b,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_status,
  output logic        fpu_start,
  output logic [31:0] fpu_op_a,
  output logic [31:0] fpu_op_b,
  input  logic        fpu_done,
  input  logic [31:0] fpu_data,
  input  logic [3:0]  fpu_status,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  if (NUM_REQ != 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fpu_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  logic [1:0]  state;
  logic        last_grant;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        win_valid;
  logic        win_id;
  logic        accept;
  logic        rsp_fire;
  logic        expired;

  always_comb begin
    win_valid = |req_valid;
    // With both requesting, the one that did not win last time goes next.
    win_id    = (req_valid == 2'b11) ? ~last_grant : ~req_valid[0];
    req_ready = 2'b00;
    if (state == ST_IDLE && reset && win_valid)
      req_ready = win_id ? 2'b10 : 2'b01;
    accept    = |(req_valid & req_ready);
    rsp_valid = (state == ST_RESP) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    rsp_fire  = (state == ST_RESP) && rsp_ready[grant_id];
    busy      = (state != ST_IDLE);
    fpu_start = (state == ST_ISSUE);
    fpu_op_a  = (state == ST_ISSUE || state == ST_WAIT) ? op_a_q : 32'h0;
    fpu_op_b  = (state == ST_ISSUE || state == ST_WAIT) ? op_b_q : 32'h0;
  end

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      wait_cnt <= '0;
    else if (state != ST_WAIT)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign expired = (state == ST_WAIT) && !fpu_done && (wait_cnt == CNT_LAST);
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      op_a_q     <= 32'h0;
      op_b_q     <= 32'h0;
      rsp_data   <= 32'h0;
      rsp_status <= 4'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            grant_id <= win_id;
            op_a_q   <= win_id ? req_op_a[63:32] : req_op_a[31:0];
            op_b_q   <= win_id ? req_op_b[63:32] : req_op_b[31:0];
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (fpu_done) begin
            rsp_data   <= fpu_data;
            rsp_status <= fpu_status;
            state      <= ST_RESP;
          end else if (expired) begin
            rsp_data   <= 32'h0;
            rsp_status <= 4'hF;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_fire) begin
            last_grant <= grant_id;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
